// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler and the producers that feed it.
package uart_tx_scheduler_pkg;

  localparam int DEFAULT_CLK_FREQ = 100_000_000;
  localparam int DEFAULT_BAUD     = 9600;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_2  = 8'h32;
  localparam logic [7:0] ASCII_3  = 8'h33;

  typedef enum logic {
    PACE_IDLE,
    PACE_GAP
  } pace_state_t;

  // One 10-bit frame plus one guard bit, in clock cycles.
  function automatic int byte_cycles(input int clk_freq, input int baud);
    return (clk_freq / baud) * 11;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push is accepted when full if a pop happens the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_send transmitter among N_REQ byte producers: per-requester capture slots,
// a round-robin grant into a shared FIFO, and a pacer that releases one byte per frame time.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD       = DEFAULT_BAUD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  output logic               busy,
  output logic               fifo_full,
  output logic [N_REQ-1:0]   ovf
);

  localparam int BYTE_CYCLES = byte_cycles(CLK_FREQ, BAUD);
  localparam int CW          = $clog2(BYTE_CYCLES);
  localparam int IW          = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] slot_full;
  logic [7:0]       slot_data [N_REQ];
  logic [IW-1:0]    rr_ptr;
  logic             grant_valid;
  logic [IW-1:0]    grant_idx;
  logic [IW-1:0]    cand;
  logic [N_REQ-1:0] grant_onehot;

  pace_state_t      state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             tx_valid_n;
  logic [7:0]       tx_data_n;
  logic             pop;
  logic             fifo_empty;
  logic [7:0]       fifo_head;

  // rr_ptr holds the index where the next search begins (one past the last grant).
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = rr_ptr;
    if (!fifo_full || pop) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!grant_valid && slot_full[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
        cand = (cand == IW'(N_REQ - 1)) ? '0 : cand + 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      grant_onehot[i] = grant_valid && (grant_idx == IW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full <= '0;
      ovf       <= '0;
      rr_ptr    <= '0;
      for (int i = 0; i < N_REQ; i++) slot_data[i] <= 8'h00;
    end else begin
      if (grant_valid) rr_ptr <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && (!slot_full[i] || grant_onehot[i])) begin
          slot_full[i] <= 1'b1;
          slot_data[i] <= req_data[8*i +: 8];
        end else if (grant_onehot[i]) begin
          slot_full[i] <= 1'b0;
        end
        if (req_valid[i] && slot_full[i] && !grant_onehot[i]) ovf[i] <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (grant_valid),
    .push_data (slot_data[grant_idx]),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PACE_IDLE;
      cnt      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      tx_valid <= tx_valid_n;
      tx_data  <= tx_data_n;
    end
  end

  // A byte is only released from IDLE, so uart_send never sees a pulse mid-frame.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    tx_valid_n = 1'b0;
    tx_data_n  = tx_data;
    pop        = 1'b0;
    case (state)
      PACE_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_data_n  = fifo_head;
          tx_valid_n = 1'b1;
          cnt_n      = CW'(BYTE_CYCLES - 1);
          state_n    = PACE_GAP;
        end
      end
      PACE_GAP: begin
        if (cnt == '0) state_n = PACE_IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = PACE_IDLE;
    endcase
  end

  assign req_ready = ~slot_full;
  assign busy      = !fifo_empty || (|slot_full) || (state != PACE_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler at CLK_FREQ=1000, BAUD=100 (110-cycle frames).
module tb_uart_tx_scheduler;

  localparam int N_REQ = 3;
  localparam int BC    = 110;
  localparam int PULSE = BC + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_REQ-1:0]  req_valid = '0;
  logic [8*N_REQ-1:0] req_data = '0;
  logic [N_REQ-1:0]  req_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              busy;
  logic              fifo_full;
  logic [N_REQ-1:0]  ovf;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] expq [$];
  bit         gap_check = 1'b0;
  bit         have_prev = 1'b0;
  int         prev_cyc = 0;

  uart_tx_scheduler #(
    .N_REQ      (N_REQ),
    .FIFO_DEPTH (8),
    .CLK_FREQ   (1000),
    .BAUD       (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .busy      (busy),
    .fifo_full (fifo_full),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops the scoreboard on every tx_valid pulse; a reset flushes whatever was still expected.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expq.delete();
        have_prev = 1'b0;
      end else if (tx_valid) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_tx actual=%0h required=no_pulse (cycle %0d)", tx_data, cyc);
        end else begin
          check_output("tx_data", {24'h0, tx_data}, {24'h0, expq.pop_front()});
        end
        if (gap_check && have_prev) check_output("tx_spacing", cyc - prev_cyc, PULSE);
        have_prev = 1'b1;
        prev_cyc  = cyc;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // Called at posedge+1; the strobe is sampled by the next rising edge.
  task automatic apply_stimulus(input logic [N_REQ-1:0] v, input logic [8*N_REQ-1:0] d);
    req_valid = v;
    req_data  = d;
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (expq.size() == 0) break;
      @(posedge clk); #1;
    end
    check_output("drain", expq.size(), 0);
    repeat (BC + 2) @(posedge clk);
    #1;
    check_output("idle_busy", {31'h0, busy}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout actual=running required=finished (cycle %0d)", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] rr_exp [11];
    logic [7:0] b0, b1;

    fork
      monitor();
    join_none

    // Single byte: latency, one-cycle pulse, busy drop after the gap.
    do_reset();
    check_output("rst_tx_valid", {31'h0, tx_valid}, 0);
    check_output("rst_tx_data", {24'h0, tx_data}, 0);
    check_output("rst_req_ready", {29'h0, req_ready}, 32'h7);
    check_output("rst_busy", {31'h0, busy}, 0);
    check_output("rst_fifo_full", {31'h0, fifo_full}, 0);
    expq.push_back(8'h31);
    apply_stimulus(3'b001, 24'h000031);
    check_output("slot0_loaded", {29'h0, req_ready}, 32'h6);
    @(posedge clk); #1;
    check_output("lat_c2_tx_valid", {31'h0, tx_valid}, 0);
    check_output("lat_c2_busy", {31'h0, busy}, 1);
    @(posedge clk); #1;
    check_output("lat_c3_tx_valid", {31'h0, tx_valid}, 1);
    check_output("lat_c3_tx_data", {24'h0, tx_data}, 32'h31);
    @(posedge clk); #1;
    check_output("pulse_width", {31'h0, tx_valid}, 0);
    check_output("tx_data_hold", {24'h0, tx_data}, 32'h31);
    repeat (108) @(posedge clk);
    #1 check_output("busy_in_gap", {31'h0, busy}, 1);
    @(posedge clk); #1;
    check_output("busy_after_gap", {31'h0, busy}, 0);

    // Contention from reset: grant order 0,1,2 with full frame spacing.
    do_reset();
    gap_check = 1'b1;
    expq.push_back(8'h31); expq.push_back(8'h32); expq.push_back(8'h33);
    apply_stimulus(3'b111, 24'h333231);
    wait_drain(400);
    check_output("contention_ovf", {29'h0, ovf}, 0);

    // Round-robin under saturation: strict 0,1 alternation, both requesters drop.
    do_reset();
    rr_exp = '{8'h40, 8'h60, 8'h41, 8'h62, 8'h43, 8'h64, 8'h45, 8'h66, 8'h47, 8'h68, 8'h49};
    for (int i = 0; i < 11; i++) expq.push_back(rr_exp[i]);
    for (int k = 0; k < 20; k++) begin
      b0 = 8'h40 + 8'(k);
      b1 = 8'h60 + 8'(k);
      apply_stimulus(3'b011, {8'h00, b1, b0});
    end
    check_output("rr_ovf", {29'h0, ovf}, 32'h3);
    check_output("rr_fifo_full", {31'h0, fifo_full}, 1);
    wait_drain(1500);

    // Full boundary: bytes 2..9 fill the FIFO, byte 10 waits in the slot, 11 and 12 drop.
    do_reset();
    for (int j = 1; j <= 10; j++) expq.push_back(8'(j));
    for (int j = 1; j <= 12; j++) begin
      apply_stimulus(3'b001, {16'h0, 8'(j)});
      if (j == 10) check_output("full_no_ovf_yet", {29'h0, ovf}, 0);
      if (j == 10) check_output("full_slot_holds", {31'h0, req_ready[0]}, 0);
      if (j == 11) check_output("full_ovf_set", {29'h0, ovf}, 32'h1);
      @(posedge clk); @(posedge clk); #1;
      if (j == 8) check_output("not_full_after_8", {31'h0, fifo_full}, 0);
      if (j == 9) check_output("full_after_9", {31'h0, fifo_full}, 1);
    end
    wait_drain(1500);

    // Reset during GAP with bytes still queued: everything flushed, nothing replayed.
    do_reset();
    gap_check = 1'b0;
    expq.push_back(8'h51);
    for (int j = 0; j < 4; j++) begin
      apply_stimulus(3'b001, {16'h0, 8'h51 + 8'(j)});
      @(posedge clk); #1;
    end
    repeat (10) @(posedge clk);
    #1 check_output("pre_reset_busy", {31'h0, busy}, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check_output("midrst_tx_valid", {31'h0, tx_valid}, 0);
    check_output("midrst_busy", {31'h0, busy}, 0);
    check_output("midrst_ovf", {29'h0, ovf}, 0);
    check_output("midrst_tx_data", {24'h0, tx_data}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1 check_output("post_reset_quiet", {31'h0, busy}, 0);
    expq.push_back(8'h77);
    apply_stimulus(3'b001, 24'h000077);
    wait_drain(20);

    // Same-cycle grant and refill on requester 2: no drop, both bytes sent.
    do_reset();
    gap_check = 1'b1;
    expq.push_back(8'hA1); expq.push_back(8'hA2);
    apply_stimulus(3'b100, 24'hA10000);
    apply_stimulus(3'b100, 24'hA20000);
    check_output("refill_ovf", {29'h0, ovf}, 0);
    wait_drain(400);
    check_output("refill_ovf_end", {29'h0, ovf}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
